// File: rtl/realign_pkg.sv
// Shared types for the fetch realigner.
//   align_case_e : alignment tag carried with every emitted instruction
//   state_e      : residual-halfword FSM state
//   is_compressed: true when a halfword starts a 16-bit instruction
package realign_pkg;

  typedef enum logic [1:0] {
    ALN_FULL  = 2'd0,  // whole 32-bit instruction taken from one fetch word
    ALN_CLO   = 2'd1,  // compressed instruction from the low half of a word
    ALN_CHI   = 2'd2,  // compressed instruction drained from the residual
    ALN_SPLIT = 2'd3   // 32-bit instruction spanning two fetch words
  } align_case_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // no residual halfword held
    S_HALF  = 2'd1,  // res_half holds the next instruction's first halfword
    S_SKIP  = 2'd2   // next fetch word's low half precedes the target PC
  } state_e;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realigner.sv
// Realigns the sequential 32-bit fetch word stream into one halfword-aligned
// instruction per cycle. Compressed instructions are zero-extended; 32-bit
// instructions that straddle two fetch words are rebuilt from a residual
// halfword buffer.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   fetch_valid/ready/word  fetch word stream (lo = [15:0], hi = [31:16])
//   flush, flush_pc         redirect pulse and target (bit 1 picks halfword)
//   instr_valid/ready       output handshake
//   instr, instr_compressed instruction and its 16-bit flag
//   instr_pc                PC of instr
//   align_case              alignment tag (realign_pkg::align_case_e)
module fetch_realigner
  import realign_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_word,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_compressed,
  output logic [31:0] instr_pc,
  output logic [1:0]  align_case
);

  localparam logic [31:0] RESET_PC_HW   = {RESET_PC[31:1], 1'b0};
  localparam state_e      RESET_STATE   = RESET_PC[1] ? S_SKIP : S_EMPTY;

  // Residual FSM state
  state_e      state_q, state_d;
  logic [15:0] res_half_q, res_half_d;
  logic [31:0] next_pc_q, next_pc_d;

  // Output register
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_c_q, instr_c_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  align_case_e align_q, align_d;

  // Emission produced by the FSM this cycle
  logic        emit;
  logic [31:0] emit_instr;
  logic        emit_c;
  align_case_e emit_case;

  logic [15:0] word_lo, word_hi;
  logic        out_free;
  logic        res_c;
  logic        fetch_fire;

  assign word_lo    = fetch_word[15:0];
  assign word_hi    = fetch_word[31:16];
  assign out_free   = !instr_valid_q || instr_ready;
  assign res_c      = is_compressed(res_half_q);
  // A buffered compressed halfword must drain before another word can enter,
  // otherwise two instructions would be ready in the same cycle.
  assign fetch_ready = out_free && !flush && !(state_q == S_HALF && res_c);
  assign fetch_fire  = fetch_valid && fetch_ready;

  always_comb begin
    state_d    = state_q;
    res_half_d = res_half_q;
    next_pc_d  = next_pc_q;
    emit       = 1'b0;
    emit_instr = 32'h0;
    emit_c     = 1'b0;
    emit_case  = ALN_FULL;

    if (flush) begin
      state_d    = flush_pc[1] ? S_SKIP : S_EMPTY;
      res_half_d = 16'h0;
      next_pc_d  = flush_pc & ~32'd1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (fetch_fire) begin
            emit = 1'b1;
            if (is_compressed(word_lo)) begin
              emit_instr = {16'h0, word_lo};
              emit_c     = 1'b1;
              emit_case  = ALN_CLO;
              res_half_d = word_hi;
              state_d    = S_HALF;
            end else begin
              emit_instr = fetch_word;
              emit_case  = ALN_FULL;
            end
          end
        end
        S_HALF: begin
          if (res_c) begin
            // Drain the buffered compressed halfword; no fetch consumed.
            if (out_free) begin
              emit       = 1'b1;
              emit_instr = {16'h0, res_half_q};
              emit_c     = 1'b1;
              emit_case  = ALN_CHI;
              state_d    = S_EMPTY;
            end
          end else if (fetch_fire) begin
            emit       = 1'b1;
            emit_instr = {word_lo, res_half_q};
            emit_case  = ALN_SPLIT;
            res_half_d = word_hi;
          end
        end
        S_SKIP: begin
          // Target PC lies in the high half: the low half is dropped.
          if (fetch_fire) begin
            res_half_d = word_hi;
            state_d    = S_HALF;
          end
        end
        default: state_d = S_EMPTY;
      endcase

      if (emit) begin
        next_pc_d = next_pc_q + (emit_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_comb begin
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_c_d     = instr_c_q;
    instr_pc_d    = instr_pc_q;
    align_d       = align_q;

    if (flush) begin
      instr_valid_d = 1'b0;
    end else if (out_free) begin
      instr_valid_d = emit;
      if (emit) begin
        instr_d    = emit_instr;
        instr_c_d  = emit_c;
        instr_pc_d = next_pc_q;
        align_d    = emit_case;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_STATE;
      res_half_q    <= 16'h0;
      next_pc_q     <= RESET_PC_HW;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_c_q     <= 1'b0;
      instr_pc_q    <= 32'h0;
      align_q       <= ALN_FULL;
    end else begin
      state_q       <= state_d;
      res_half_q    <= res_half_d;
      next_pc_q     <= next_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_c_q     <= instr_c_d;
      instr_pc_q    <= instr_pc_d;
      align_q       <= align_d;
    end
  end

  assign instr_valid      = instr_valid_q;
  assign instr            = instr_q;
  assign instr_compressed = instr_c_q;
  assign instr_pc         = instr_pc_q;
  assign align_case       = align_q;

endmodule

// File: doc/fetch_realigner.md
# fetch_realigner

Front-end realignment stage between instruction fetch and decode. It consumes the sequential 32-bit fetch word stream and emits one halfword-aligned instruction per cycle: a full 32-bit instruction, or a 16-bit compressed one zero-extended. A residual-halfword buffer rebuilds 32-bit instructions that straddle two fetch words. It deasserts `fetch_ready` while a buffered compressed halfword drains, and tags each instruction with its alignment case for the compressed-stall logic downstream.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC of the first instruction after reset; bit 0 is ignored.

- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `fetch_valid` in 1: `fetch_word` is valid.
- `fetch_ready` out 1: realigner accepts `fetch_word` this cycle.
- `fetch_word` in 32: next sequential word-aligned fetch word; lo = [15:0], hi = [31:16].
- `flush` in 1: redirect pulse.
- `flush_pc` in 32: redirect target; bit 1 selects halfword.
- `instr_valid` out 1: output instruction valid.
- `instr_ready` in 1: decode accepts the instruction.
- `instr` out 32: instruction; compressed ones are zero-extended.
- `instr_compressed` out 1: `instr` is 16-bit.
- `instr_pc` out 32: PC of `instr`.
- `align_case` out 2: alignment tag, `align_case_e`.

## Operation
- A halfword is compressed iff bits [1:0] != 2'b11.
- Transfers:
  - Fetch transfer = `fetch_valid & fetch_ready`.
  - Output transfer = `instr_valid & instr_ready`.
  - `out_free = !instr_valid | instr_ready`.
- Residual state: `res_half[15:0]`, plus state FSM `S_EMPTY`, `S_HALF`, `S_SKIP`.
- `fetch_ready = out_free & !flush & !(state==S_HALF & res_half compressed)`.
- S_EMPTY, on a fetch transfer:
  - lo is 32-bit: emit the whole word, `ALN_FULL`; stay in S_EMPTY.
  - lo is compressed: emit lo, `ALN_CLO`; hi goes to `res_half`; go to S_HALF.
- S_HALF, `res_half` compressed: when `out_free`, emit `res_half`, `ALN_CHI`, without consuming fetch; go to S_EMPTY.
- S_HALF, `res_half` is the lower half of a 32-bit instruction: on a fetch transfer, emit `{lo, res_half}`, `ALN_SPLIT`; hi becomes the new `res_half`; stay in S_HALF.
- S_SKIP, on a fetch transfer: discard lo, store hi in `res_half`, emit nothing; go to S_HALF.
- PC tracking: internal `next_pc` advances by 2 (compressed) or 4 on each emission, modulo 2^32. `instr_pc` is `next_pc` at emission time.
- `flush` takes priority over every other event in its cycle:
  - Any same-cycle fetch word is dropped.
  - `instr_valid` clears next cycle.
  - `res_half` is invalidated.
  - `next_pc` loads `{flush_pc[31:1],1'b0}`.
  - State goes to S_SKIP if `flush_pc[1]`, else S_EMPTY.
- The output register loads only when `out_free`. While `instr_valid & !instr_ready`, all output fields hold stable.

## Timing
- Latency: instruction registered 1 cycle after its completing fetch transfer (or after the S_HALF compressed drain decision).
- Throughput: at most 1 instruction per cycle. A word holding two compressed halves takes 2 cycles, with `fetch_ready` low in the second.
- Reset values:
  - `instr_valid`=0, `instr`=0, `instr_compressed`=0, `instr_pc`=0, `align_case`=`ALN_FULL`.
  - `res_half`=0; `next_pc`=`RESET_PC` with bit 0 cleared.
  - State = S_SKIP if `RESET_PC[1]`, else S_EMPTY.
  - `fetch_ready`=1 in the first cycle after reset release.
- Reset mid-operation: residual and output instruction are lost with no emission, and the reset values above apply.
- `fetch_word` content is ignored when no fetch transfer occurs.

## Structure
- Package `realign_pkg`:
  - `typedef enum logic [1:0] {ALN_FULL, ALN_CLO, ALN_CHI, ALN_SPLIT} align_case_e`.
  - State enum.
  - Function `is_compressed(logic [15:0])`.
- No sub-module; a single FSM plus output register.

## Test plan
- Aligned 32-bit: reset, feed `0x00000013` → next cycle `instr`=`0x00000013`, `instr_compressed`=0, `instr_pc`=0, `ALN_FULL`.
- Two compressed halves: feed `0x45014505` → `instr`=`0x00004505` @pc 0 `ALN_CLO`; then `fetch_ready`=0 for one cycle; then `0x00004501` @pc 2 `ALN_CHI`.
- Straddling instruction: feed `0x00134505` then `0x45050000` → three instructions in order:
  - `0x4505` @0 (`ALN_CLO`)
  - `0x00000013` @2 (`ALN_SPLIT`)
  - `0x4505` @6 (`ALN_CHI`)
- Backpressure: hold `instr_ready`=0 for 3 cycles with a valid instruction → all outputs stable, `fetch_ready`=0, no word consumed; the next instruction appears 1 cycle after `instr_ready` rises.
- Flush to `0x102` while `fetch_valid`=1:
  - The same-cycle word is dropped and `instr_valid`=0 next cycle.
  - Next, feed `0x4501xxxx`, then any word → `instr`=`0x00004501` @pc `0x102` `ALN_CHI`.
- Reset asserted in S_HALF with `res_half`=`0x0013` → all outputs return to reset values and no stale instruction is ever emitted.
